// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode/funct encodings, instruction and flag layouts.
package alu_pkg;

  localparam int unsigned OPC_W   = 2;
  localparam int unsigned FUNCT_W = 3;
  localparam int unsigned RSEL_W  = 2;
  localparam int unsigned FLAGS_W = 4;

  localparam logic [OPC_W-1:0] OP_R = 2'b00;

  typedef enum logic [FUNCT_W-1:0] {
    R_ADD = 3'b000,
    R_AND = 3'b001,
    R_OR  = 3'b010,
    R_SUB = 3'b011,
    R_XOR = 3'b100,
    R_SLL = 3'b101,
    R_SRL = 3'b110,
    R_SRA = 3'b111
  } funct_e;

  // Instruction word, MSB first: register selectors, funct, format bit, opcode.
  typedef struct packed {
    logic [RSEL_W-1:0] rsel;
    funct_e            funct;
    logic              fmt;
    logic [OPC_W-1:0]  opcode;
  } instr_t;

  // Flag word: bit3 V, bit2 C, bit1 N, bit0 Z.
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

  // An R-op is the only instruction class the ALU acts on.
  function automatic logic is_rop(input instr_t ins);
    return (ins.opcode == OP_R) && !ins.fmt;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU with a registered {V,C,N,Z} flag word.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out,
  output logic [3:0]    flags
);

  localparam int unsigned SW = $clog2(DW);

  instr_t        ins;
  logic          valid;
  logic          unused_rsel;

  logic          is_sub;
  logic [DW-1:0] opb;
  logic [DW:0]   sum;
  logic          add_v;

  logic [SW-1:0] shamt;
  logic [DW-1:0] res;
  logic          res_c;
  logic          res_v;

  flags_t        flags_d;
  flags_t        flags_q;

  // Field decode; register selectors are not ALU inputs.
  assign ins         = instr_t'(instruction[7:0]);
  assign valid       = is_rop(ins);
  assign unused_rsel = ^ins.rsel;
  assign shamt       = rs1_data[SW-1:0];

  // Shared adder: SUB inverts rs1 and injects the +1 as carry in.
  always_comb begin
    is_sub = (ins.funct == R_SUB);
    opb    = is_sub ? ~rs1_data : rs1_data;
    sum    = {1'b0, rd_data} + {1'b0, opb} + (DW+1)'(is_sub);
    add_v  = (rd_data[DW-1] == opb[DW-1]) && (sum[DW-1] != rd_data[DW-1]);
  end

  // Result mux and carry/overflow selection; invalid ops give zero.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    if (valid) begin
      unique case (ins.funct)
        R_ADD, R_SUB: begin
          res   = sum[DW-1:0];
          res_c = sum[DW];
          res_v = add_v;
        end
        R_AND:   res = rd_data & rs1_data;
        R_OR:    res = rd_data | rs1_data;
        R_XOR:   res = rd_data ^ rs1_data;
        R_SLL:   res = rd_data << shamt;
        R_SRL:   res = rd_data >> shamt;
        R_SRA:   res = DW'($signed(rd_data) >>> shamt);
        default: res = '0;
      endcase
    end
  end

  // Next flag word from the current result.
  always_comb begin
    flags_d   = '0;
    flags_d.v = res_v;
    flags_d.c = res_c;
    flags_d.n = res[DW-1];
    flags_d.z = (res == '0);
  end

  // Flag register: reset wins; invalid instructions leave flags untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (valid) begin
      flags_q <= flags_d;
    end
  end

  assign out   = res;
  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized ops against a reference model.
module tb_alu;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instruction;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out;
  logic [3:0]    flags;

  int            checks   = 0;
  int            failures = 0;
  logic [3:0]    exp_flags;

  alu #(.DW(DW), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .rs1_data    (rs1_data),
    .rd_data     (rd_data),
    .out         (out),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  // Build an R-op word from selector bits and funct code.
  function automatic logic [7:0] mk(input int sel, input int funct);
    logic [7:0] w;
    w = {2'(sel), 3'(funct), 1'b0, 2'b00};
    return w;
  endfunction

  // Reference model using integer arithmetic on the instruction's meaning.
  function automatic void ref_alu(input logic [7:0] ins, input logic [DW-1:0] rs1,
                                  input logic [DW-1:0] rd, output logic [DW-1:0] res,
                                  output logic [3:0] flg, output bit ok);
    int unsigned ua, ub, modv;
    int          sa, sb, s, sh, smax, smin;
    bit          v, c;
    modv = 1 << DW;
    ua   = int'(rd);
    ub   = int'(rs1);
    sa   = int'($signed(rd));
    sb   = int'($signed(rs1));
    smax = int'(modv / 2) - 1;
    smin = -int'(modv / 2);
    sh   = int'(ub % DW);
    ok   = (ins[1:0] == 2'b00) && (ins[2] == 1'b0);
    v    = 0;
    c    = 0;
    res  = '0;
    if (ok) begin
      case (int'(ins[5:3]))
        0: begin s = sa + sb; res = DW'((ua + ub) % modv); c = (ua + ub) >= modv; v = (s > smax) || (s < smin); end
        3: begin s = sa - sb; res = DW'((ua + modv - ub) % modv); c = ua >= ub; v = (s > smax) || (s < smin); end
        1: res = rd & rs1;
        2: res = rd | rs1;
        4: res = rd ^ rs1;
        5: res = DW'((ua << sh) % modv);
        6: res = DW'(ua >> sh);
        default: res = DW'(sa >>> sh);
      endcase
    end
    flg = {v, c, res[DW-1], (res == '0)};
  endfunction

  // Drive one instruction on the falling edge, check out, clock it, check flags.
  task automatic step(input logic [7:0] ins, input logic [DW-1:0] a_rs1, input logic [DW-1:0] b_rd,
                      input bit r, input bit chk_k, input logic [DW-1:0] k);
    logic [DW-1:0] eo;
    logic [3:0]    ef;
    bit            ok;
    @(negedge clk);
    instruction = ins;
    rs1_data    = a_rs1;
    rd_data     = b_rd;
    rst         = r;
    #1;
    ref_alu(ins, a_rs1, b_rd, eo, ef, ok);
    checks++;
    assert (out === eo) else begin
      failures++;
      $error("FAIL out ins=%h rs1=%h rd=%h got=%h exp=%h", ins, a_rs1, b_rd, out, eo);
    end
    if (chk_k) begin
      checks++;
      assert (out === k) else begin
        failures++;
        $error("FAIL vec ins=%h rs1=%h rd=%h got=%h exp=%h", ins, a_rs1, b_rd, out, k);
      end
    end
    @(posedge clk);
    #1;
    if (r) exp_flags = 4'b0000;
    else if (ok) exp_flags = ef;
    checks++;
    assert (flags === exp_flags) else begin
      failures++;
      $error("FAIL flags ins=%h rs1=%h rd=%h rst=%0d got=%b exp=%b", ins, a_rs1, b_rd, r, flags, exp_flags);
    end
  endtask

  logic [7:0] add_rd  [5] = '{8'h00, 8'hFF, 8'h01, 8'hFF, 8'h11};
  logic [7:0] add_rs  [5] = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h22};
  logic [7:0] add_k   [5] = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h33};
  logic [7:0] lg_fn   [5] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
  logic [7:0] lg_rd   [5] = '{8'hFF, 8'hA8, 8'hFF, 8'hA8, 8'h00};
  logic [7:0] lg_rs   [5] = '{8'hAA, 8'h89, 8'hAA, 8'h89, 8'hFF};
  logic [7:0] lg_k    [5] = '{8'hAA, 8'h88, 8'hFF, 8'hA9, 8'hFF};

  initial begin
    logic [7:0] ri;
    bit         rr;

    rst         = 1'b1;
    instruction = '0;
    rs1_data    = '0;
    rd_data     = '0;
    exp_flags   = 4'b0000;

    // Reset state.
    @(posedge clk);
    #1;
    checks++;
    assert (flags === 4'b0000) else begin
      failures++;
      $error("FAIL reset_flags got=%b exp=%b", flags, 4'b0000);
    end

    // ADD, AND, OR across all selector values.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 5; i++) step(mk(s, 0), add_rs[i], add_rd[i], 1'b0, 1'b1, add_k[i]);
      for (int i = 0; i < 5; i++) step(mk(s, int'(lg_fn[i])), lg_rs[i], lg_rd[i], 1'b0, 1'b1, lg_k[i]);
    end

    // SUB and shifts, including ignored upper shift-amount bits.
    step(mk(0, 3), 8'h07, 8'h05, 1'b0, 1'b1, 8'hFE);
    step(mk(1, 5), 8'h01, 8'h81, 1'b0, 1'b1, 8'h02);
    step(mk(2, 6), 8'h01, 8'h81, 1'b0, 1'b1, 8'h40);
    step(mk(3, 7), 8'h01, 8'h81, 1'b0, 1'b1, 8'hC0);
    step(mk(0, 7), 8'h09, 8'h81, 1'b0, 1'b1, 8'hC0);

    // Flag vectors.
    step(mk(0, 0), 8'h01, 8'hFF, 1'b0, 1'b1, 8'h00);
    checks++;
    assert (flags === 4'b0101) else begin
      failures++;
      $error("FAIL flags_carry_zero got=%b exp=%b", flags, 4'b0101);
    end
    step(mk(2, 0), 8'h01, 8'h7F, 1'b0, 1'b1, 8'h80);
    checks++;
    assert (flags === 4'b1010) else begin
      failures++;
      $error("FAIL flags_overflow got=%b exp=%b", flags, 4'b1010);
    end

    // Invalid opcode holds flags; format bit set is also invalid.
    step(8'b00_000_0_01, 8'h01, 8'hFF, 1'b0, 1'b1, 8'h00);
    checks++;
    assert (flags === 4'b1010) else begin
      failures++;
      $error("FAIL flags_hold got=%b exp=%b", flags, 4'b1010);
    end
    step(8'b00_000_1_00, 8'h01, 8'h01, 1'b0, 1'b1, 8'h00);

    // Reset clears flags while out keeps tracking its inputs.
    step(mk(0, 0), 8'h22, 8'h11, 1'b1, 1'b1, 8'h33);
    checks++;
    assert (flags === 4'b0000) else begin
      failures++;
      $error("FAIL flags_rst got=%b exp=%b", flags, 4'b0000);
    end

    // Randomized traffic, biased toward valid R-ops, with occasional reset.
    for (int n = 0; n < 400; n++) begin
      ri = 8'($urandom);
      if ($urandom_range(0, 3) != 0) ri[2:0] = 3'b000;
      rr = ($urandom_range(0, 24) == 0);
      step(ri, DW'($urandom), DW'($urandom), rr, 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter DW, default 8, data width in bits (>= 4, power of two).
REQ-002 Parameter IW, default 8, instruction width in bits (fixed at 8 for this encoding).
REQ-003 clk  input  1  single clock; only the flag register uses it.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instruction  input  IW  instruction word.
REQ-006 rs1_data  input  DW  source register value, signed two's complement.
REQ-007 rd_data  input  DW  destination register current value, signed two's complement.
REQ-008 out  output  DW  combinational result, signed.
REQ-009 flags  output  4  registered {V,C,N,Z}: bit3 V, bit2 C, bit1 N, bit0 Z.

Function
REQ-010 Encoding: [1:0] opcode; [2] format bit; [5:3] funct; [7:6] register selectors, ignored by the ALU.
REQ-011 Valid R-op: opcode == OP_R (2'b00) and bit[2] == 0; anything else invalid.
REQ-012 funct codes: R_ADD 000, R_AND 001, R_OR 010, R_SUB 011, R_XOR 100, R_SLL 101, R_SRL 110, R_SRA 111.
REQ-013 out is purely combinational from instruction, rs1_data and rd_data; settles within the same timestep, no clock latency.
REQ-014 ADD: out = (rd_data + rs1_data) mod 2^DW; carry out is dropped from out.
REQ-015 SUB: out = (rd_data - rs1_data) mod 2^DW.
REQ-016 AND, OR, XOR: out = bitwise rd_data op rs1_data.
REQ-017 SLL/SRL/SRA: rd_data shifted by rs1_data[$clog2(DW)-1:0]; upper rs1 bits ignored; SRA sign-fills, SRL and SLL zero-fill.
REQ-018 Invalid instruction: out = 0.
REQ-019 Bits [7:6] have no effect on out or flags.
REQ-020 Flags are computed combinationally from the current valid op and captured on posedge clk.
REQ-021 Z = (out == 0); N = out[DW-1].
REQ-022 C: ADD carry out of bit DW-1; SUB carry of rd + ~rs1 + 1 (1 = no borrow); 0 for logic and shift ops.
REQ-023 V: ADD/SUB signed overflow; 0 for other ops.
REQ-024 Invalid instruction: flags hold their previous value.

Reset
REQ-025 On posedge clk with rst=1, flags become 4'b0000; rst has priority over flag capture.
REQ-026 rst has no effect on out, which stays combinational.

Structure
REQ-027 A shared definitions file holds opcode constants (OP_R) and funct constants (R_ADD ... R_SRA); the ALU and the decoder both use it.
REQ-028 A single module; no sub-modules are required. The add/sub adder is shared, with the operand inverted for SUB.

Verification
REQ-029 ADD with all four values of [7:6]: 00+00->00; FF+01->00; 01+FF->00; FF+FF->FE; 11+22->33; out identical for each [7:6].
REQ-030 AND and OR with all four values of [7:6]: FF&AA->AA; A8&89->88; FF|AA->FF; A8|89->A9; 00|FF->FF.
REQ-031 SUB and shifts: 05-07->FE; SLL 81 by 1->02; SRL 81 by 1->40; SRA 81 by 1->C0; SRA by rs1=09 shifts by 1.
REQ-032 Flags: ADD 7F+01 then clk -> flags V=1,N=1,C=0,Z=0; ADD FF+01 then clk -> C=1,Z=1,V=0.
REQ-033 Invalid op (opcode 01) -> out=00 and flags unchanged after clk; rst=1 on clk -> flags=0000 while out still tracks its inputs.
